// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the sequential restoring divider.
//   state_e    : divider FSM states (IDLE, RUN, DONE)
//   cnt_width  : width of the iteration counter, $clog2(width + 1), so that it
//                can hold the value WIDTH itself
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : div_pkg

// File: rtl/div_addsub.sv
// -----------------------------------------------------------------------------
// div_addsub
// W-bit ripple-carry adder/subtractor. Subtraction is a + ~b + 1, so the same
// chain serves both operations.
//   a, b      : operands
//   sub       : 0 = a + b, 1 = a - b
//   sum       : W-bit result
//   carry_out : carry out of the MSB; for subtraction 1 means "no borrow"
// -----------------------------------------------------------------------------
module div_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  logic [W-1:0] b_x;
  logic [W:0]   c;

  // Inverting B and injecting sub as the carry-in turns the adder into a
  // two's-complement subtractor.
  assign b_x = b ^ {W{sub}};

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional code, otherwise synthesis infers a latch.
    sum  = '0;
    c    = '0;
    c[0] = sub;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b_x[i] ^ c[i];
      c[i+1]   = (a[i] & b_x[i]) | (a[i] & c[i]) | (b_x[i] & c[i]);
    end
  end

  assign carry_out = c[W];

endmodule : div_addsub

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
// Multi-cycle restoring divider producing one quotient bit per clock.
// Build option: define SIGNED_DIV_EN for two's-complement operands (magnitudes
// taken at load, signs applied when results are written); otherwise unsigned.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, accepted in IDLE or DONE
//   dividend     : numerator, captured on the accepting edge
//   divisor      : denominator, captured on the accepting edge
//   busy         : high while iterating
//   done         : one-cycle pulse when results become valid
//   quotient     : result quotient, held until the next done
//   remainder    : result remainder, held until the next done
//   div_by_zero  : captured divisor was zero, valid with done and held
// -----------------------------------------------------------------------------
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;          // partial remainder
  logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out / quotient in
  logic [WIDTH-1:0] dsr_q, dsr_d;      // captured divisor magnitude
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // ---------------------------------------------------------------------------
  // Restoring step: {R,Q} << 1, then trial subtract at WIDTH+1 bits.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  assign shifted = {r_q, q_q[WIDTH-1]};

  div_addsub #(.W(WIDTH + 1)) u_trial (
    .a         (shifted),
    .b         ({1'b0, dsr_q}),
    .sub       (1'b1),
    .sum       (trial),
    .carry_out (no_borrow)
  );

  // A kept trial result is always below the divisor, so WIDTH bits suffice.
  assign r_step = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_step = {q_q[WIDTH-2:0], no_borrow};

  // ---------------------------------------------------------------------------
  // Operand conditioning and result sign fix-up.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mag_dvd;
  logic [WIDTH-1:0] mag_dsr;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;
  logic             unused_trial;

  assign unused_trial = trial[WIDTH];

`ifdef SIGNED_DIV_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH:0]   neg_dvd, neg_dsr, neg_quo, neg_rem;
  logic [3:0]       neg_co;
  logic             unused_neg;

  div_addsub #(.W(WIDTH + 1)) u_neg_dvd (
    .a ('0), .b ({1'b0, dividend}), .sub (1'b1), .sum (neg_dvd), .carry_out (neg_co[0])
  );
  div_addsub #(.W(WIDTH + 1)) u_neg_dsr (
    .a ('0), .b ({1'b0, divisor}), .sub (1'b1), .sum (neg_dsr), .carry_out (neg_co[1])
  );
  div_addsub #(.W(WIDTH + 1)) u_neg_quo (
    .a ('0), .b ({1'b0, q_step}), .sub (1'b1), .sum (neg_quo), .carry_out (neg_co[2])
  );
  div_addsub #(.W(WIDTH + 1)) u_neg_rem (
    .a ('0), .b ({1'b0, r_step}), .sub (1'b1), .sum (neg_rem), .carry_out (neg_co[3])
  );

  // The most-negative value negates to itself, which read as unsigned is its
  // true magnitude, so no extra width is needed.
  assign mag_dvd = dividend[WIDTH-1] ? neg_dvd[WIDTH-1:0] : dividend;
  assign mag_dsr = divisor[WIDTH-1]  ? neg_dsr[WIDTH-1:0] : divisor;
  assign quo_fin = neg_quo_q ? neg_quo[WIDTH-1:0] : q_step;
  assign rem_fin = neg_rem_q ? neg_rem[WIDTH-1:0] : r_step;

  // A zero divisor keeps the all-ones quotient as is; the remainder sign
  // restore then gives back the original dividend.
  assign neg_quo_d = (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && (divisor != '0);
  assign neg_rem_d = dividend[WIDTH-1];

  assign unused_neg = ^{neg_co, neg_dvd[WIDTH], neg_dsr[WIDTH],
                        neg_quo[WIDTH], neg_rem[WIDTH]};
`else
  assign mag_dvd = dividend;
  assign mag_dsr = divisor;
  assign quo_fin = q_step;
  assign rem_fin = r_step;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    r_d           = r_q;
    q_d           = q_q;
    dsr_d         = dsr_q;
    dbz_pend_d    = dbz_pend_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d    = RUN;
          busy_d     = 1'b1;
          cnt_d      = CNT_W'(WIDTH);
          r_d        = '0;
          q_d        = mag_dvd;
          dsr_d      = mag_dsr;
          dbz_pend_d = (divisor == '0);
        end
      end
      RUN: begin
        r_d    = r_step;
        q_d    = q_step;
        cnt_d  = cnt_q - CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d       = DONE;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          quotient_d    = quo_fin;
          remainder_d   = rem_fin;
          div_by_zero_d = dbz_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: there are no memories here, so every register is reset; this keeps
  // the outputs at 0 immediately when an operation is aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      r_q           <= '0;
      q_q           <= '0;
      dsr_q         <= '0;
      dbz_pend_q    <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, independent of statement order.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      r_q           <= r_d;
      q_q           <= q_d;
      dsr_q         <= dsr_d;
      dbz_pend_q    <= dbz_pend_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef SIGNED_DIV_EN
  // Sign flags only change on the accepting edge; loading them every cycle
  // start is accepted is harmless because they are unused outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (start && (state_q != RUN)) begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
// Directed bench for seq_restoring_divider (WIDTH=4). Expected results come
// from a behavioural model, queued when an operation is launched and popped
// when done is seen.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] held_q   = '0;
  logic [W-1:0] held_r   = '0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   qi, ri;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      qi = int'($signed(a)) / int'($signed(b));
      ri = int'($signed(a)) % int'($signed(b));
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      e.q   = qi[W-1:0];
      e.r   = ri[W-1:0];
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Drives start for one cycle; returns at the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, checking busy length and result stability;
  // returns at the negedge where done is high.
  task automatic collect(input string tag);
    int   cyc      = 0;
    int   busy_cnt = 0;
    exp_t e;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) begin
        busy_cnt++;
        check({tag, "_hold_q"}, quotient, held_q);
        check({tag, "_hold_r"}, remainder, held_r);
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_cycles"}, busy_cnt, W);
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, quotient, e.q);
      check({tag, "_remainder"}, remainder, e.r);
      check({tag, "_div_by_zero"}, div_by_zero, e.dbz);
      check({tag, "_busy_low_at_done"}, busy, 0);
      held_q = e.q;
      held_r = e.r;
    end
  endtask

  // Done must drop after one cycle while results hold.
  task automatic pulse_check(input string tag);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_result_held"}, quotient, held_q);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    launch(4'd13, 4'd3);
    collect("13_3");
    pulse_check("13_3");

    launch(4'd15, 4'd1);
    collect("15_1");
    pulse_check("15_1");

    launch(4'd2, 4'd7);
    collect("2_7");
    pulse_check("2_7");

    launch(4'd5, 4'd0);
    collect("5_0");
    pulse_check("5_0");
    check("dbz_held", div_by_zero, 1);

    launch(4'd7, 4'd3);
    collect("7_3_dbz_clear");
    pulse_check("7_3");

    // Start during busy is ignored; the same held start is taken in DONE.
    launch(4'd9, 4'd2);
    start    = 1'b1;
    dividend = 4'd8;
    divisor  = 4'd8;
    collect("9_2_ignore");
    sb.push_back(model(4'd8, 4'd8));
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_after_done", busy, 1);
    check("b2b_done_low", done, 0);
    collect("8_8_b2b");
    pulse_check("8_8");

    // Reset in the second RUN cycle aborts the operation.
    launch(4'd14, 4'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    void'(sb.pop_back());
    held_q = '0;
    held_r = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst_n = 1'b1;

    launch(4'd6, 4'd4);
    collect("6_4_after_rst");
    pulse_check("6_4");

`ifdef SIGNED_DIV_EN
    launch(4'b1001, 4'd2);
    collect("m7_2");
    check("m7_2_q_lit", quotient, 4'b1101);
    check("m7_2_r_lit", remainder, 4'b1111);
    pulse_check("m7_2");

    launch(4'b1000, 4'b1111);
    collect("m8_m1");
    check("m8_m1_q_lit", quotient, 4'b1000);
    check("m8_m1_r_lit", remainder, 4'b0000);
    pulse_check("m8_m1");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_restoring_divider
